// File: rtl/cpu_pkg.sv
// Shared constants for the fetch path: FSM encoding, default reset PC and
// the opcodes of the control-transfer instructions that redirect fetch.
package cpu_pkg;

    // Fetch FSM encoding (plain constants so older tools can consume them)
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Opcodes found in instr[31:26]
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

endpackage : cpu_pkg

// File: rtl/next_pc_calc.sv
// Combinational redirect decision and target computation for resolving
// control-transfer instructions. A jump wins over a branch.
module next_pc_calc (
    input  logic        br_valid,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // Branch/jump targets and the taken decision
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every
        // output on every path, so no latch can be inferred.
        br_off    = {{14{br_imm[15]}}, br_imm, 2'b00};
        br_target = br_pc4 + br_off;            // wraps modulo 2^32
        j_target  = {br_pc4[31:28], j_index, 2'b00};
        redirect  = br_valid & (jump | (branch & (zero ^ bne)));
        target    = jump ? j_target : br_target;
    end

endmodule : next_pc_calc

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch unit. Issues a word fetch, waits for
// the response, then holds the instruction until the decoder accepts it.
// Redirects from the resolve stage reload the PC; a response already in
// flight when a redirect hits is dropped on arrival.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        br_valid,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc_inc;
    logic        redirect;
    logic [31:0] target;

    next_pc_calc u_next_pc_calc (
        .br_valid (br_valid),
        .branch   (branch),
        .bne      (bne),
        .jump     (jump),
        .zero     (zero),
        .br_pc4   (br_pc4),
        .br_imm   (br_imm),
        .j_index  (j_index),
        .redirect (redirect),
        .target   (target)
    );

    // Next-state logic for the fetch FSM, PC, drop flag and output buffer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        pc_inc  = pc_q + 32'd4;                 // wraps FFFF_FFFC -> 0

        case (state_q)
            ST_FETCH: begin
                // A redirect here retargets the fetch; no request leaves
                // this cycle, so nothing is outstanding for the old PC.
                if (redirect) pc_d = target;
                else          state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) pc_d = target;
                if (imem_rvalid) begin
                    if (redirect || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_inc;
                        pc_d    = pc_inc;
                        state_d = ST_FULL;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            ST_FULL: begin
                // An accept coinciding with a redirect still consumes the
                // buffered instruction; the redirect only changes the PC.
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (id_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    // Output decode; the request is held low while reset is asserted
    always_comb begin
        imem_req    = rst_n & (state_q == ST_FETCH) & ~redirect;
        imem_addr   = pc_q;
        instr_valid = (state_q == ST_FULL);
        instr_out   = instr_q;
        pc4_out     = pc4_q;
    end

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: the memory is driven step by step and
// every expected value is written out by hand.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic        instr_valid;
    logic        id_ready;
    logic        br_valid;
    logic        branch;
    logic        bne;
    logic        jump;
    logic        zero;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic [25:0] j_index;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc4_out     (pc4_out),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .br_valid    (br_valid),
        .branch      (branch),
        .bne         (bne),
        .jump        (jump),
        .zero        (zero),
        .br_pc4      (br_pc4),
        .br_imm      (br_imm),
        .j_index     (j_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 2 time units after the edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_br();
        br_valid = 1'b0; branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
        br_pc4 = '0; br_imm = '0; j_index = '0;
    endtask

    initial begin
        rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        clear_br();

        // Reset values
        repeat (2) cyc();
        #1;
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr_out,            32'd0);
        check("rst_pc4",   pc4_out,              32'd0);
        check("rst_addr",  imem_addr,            32'd0);

        // Reset release: request at RESET_PC, response one cycle later
        rst_n = 1'b1;
        #1;
        check("s1_req",  {31'd0, imem_req}, 32'd1);
        check("s1_addr", imem_addr,         32'h0);
        cyc();                                    // -> WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h2409_0005;
        #1;
        check("s1_wait_req",   {31'd0, imem_req},    32'd0);
        check("s1_wait_valid", {31'd0, instr_valid}, 32'd0);
        cyc();                                    // -> FULL
        imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        check("s1_valid", {31'd0, instr_valid}, 32'd1);
        check("s1_instr", instr_out,            32'h2409_0005);
        check("s1_pc4",   pc4_out,              32'd4);

        // Decoder stalls 5 cycles; a stray response in FULL is ignored
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 2);
            imem_rdata  = (i == 2) ? 32'hBAD0_BAD0 : 32'h0;
            cyc();
            imem_rvalid = 1'b0;
            #1;
            check("s2_hold_valid", {31'd0, instr_valid}, 32'd1);
            check("s2_hold_instr", instr_out,            32'h2409_0005);
            check("s2_hold_pc4",   pc4_out,              32'd4);
            check("s2_hold_req",   {31'd0, imem_req},    32'd0);
        end
        id_ready = 1'b1;
        cyc();                                    // accept -> FETCH
        id_ready = 1'b0;
        #1;
        check("s2_req",   {31'd0, imem_req},    32'd1);
        check("s2_addr",  imem_addr,            32'd4);
        check("s2_valid", {31'd0, instr_valid}, 32'd0);

        // Taken beq resolved in FULL, coincident with acceptance
        cyc();                                    // -> WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h1000_FFFC;
        cyc();                                    // -> FULL, pc=8
        imem_rvalid = 1'b0;
        #1;
        check("s3_pc4", pc4_out, 32'd8);
        br_valid = 1'b1; branch = 1'b1; zero = 1'b1;
        br_pc4 = 32'h10; br_imm = 16'hFFFC; id_ready = 1'b1;
        cyc();                                    // -> FETCH at target
        clear_br(); id_ready = 1'b0;
        #1;
        check("s3_req",   {31'd0, imem_req},    32'd1);
        check("s3_addr",  imem_addr,            32'h0);
        check("s3_valid", {31'd0, instr_valid}, 32'd0);

        // bne with zero=1: not taken, fetch continues sequentially
        cyc();                                    // -> WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h1400_0003;
        cyc();                                    // -> FULL, pc=4
        imem_rvalid = 1'b0;
        br_valid = 1'b1; bne = 1'b1; branch = 1'b1; zero = 1'b1;
        br_pc4 = 32'h40; br_imm = 16'h0010; id_ready = 1'b1;
        #1;
        check("s4_instr", instr_out, 32'h1400_0003);
        cyc();                                    // accept -> FETCH
        clear_br(); id_ready = 1'b0;
        #1;
        check("s4_req",  {31'd0, imem_req}, 32'd1);
        check("s4_addr", imem_addr,         32'd4);

        // Jump during WAIT: response dropped, refetch at jump target
        cyc();                                    // -> WAIT
        br_valid = 1'b1; jump = 1'b1; br_pc4 = 32'hA000_0008; j_index = 26'h10;
        cyc();                                    // drop set, pc=target
        clear_br();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("s5_wait_req", {31'd0, imem_req}, 32'd0);
        cyc();                                    // dropped -> FETCH
        imem_rvalid = 1'b0;
        #1;
        check("s5_valid", {31'd0, instr_valid}, 32'd0);
        check("s5_req",   {31'd0, imem_req},    32'd1);
        check("s5_addr",  imem_addr,            32'hA000_0040);

        // Redirect coincident with the response in WAIT discards it
        cyc();                                    // -> WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        br_valid = 1'b1; jump = 1'b1; br_pc4 = 32'h0; j_index = 26'h20;
        cyc();                                    // -> FETCH at 0x80
        clear_br(); imem_rvalid = 1'b0;
        #1;
        check("s5b_valid", {31'd0, instr_valid}, 32'd0);
        check("s5b_addr",  imem_addr,            32'h80);

        // Two redirects while the response is pending: the last one wins
        cyc();                                    // -> WAIT
        br_valid = 1'b1; jump = 1'b1; br_pc4 = 32'h0; j_index = 26'h40;
        cyc();                                    // drop set, pc=0x100
        br_pc4 = 32'hF000_0000; j_index = 26'h3FF_FFFF;
        cyc();                                    // pc=FFFF_FFFC, still dropping
        clear_br();
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        cyc();                                    // dropped -> FETCH
        imem_rvalid = 1'b0;
        #1;
        check("s5c_valid", {31'd0, instr_valid}, 32'd0);
        check("s5c_addr",  imem_addr,            32'hFFFF_FFFC);

        // Fetch at the top of the address space wraps to 0
        cyc();                                    // -> WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h0800_0000;
        cyc();                                    // -> FULL
        imem_rvalid = 1'b0;
        #1;
        check("s6_valid", {31'd0, instr_valid}, 32'd1);
        check("s6_instr", instr_out,            32'h0800_0000);
        check("s6_pc4",   pc4_out,              32'h0);
        id_ready = 1'b1;
        cyc();                                    // accept -> FETCH
        id_ready = 1'b0;
        #1;
        check("s6_addr", imem_addr, 32'h0);

        // Reset in WAIT; the late response afterwards is ignored
        cyc();                                    // -> WAIT
        rst_n = 1'b0;
        #1;
        check("s7_rst_req", {31'd0, imem_req}, 32'd0);
        cyc();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        #1;
        check("s7_req",  {31'd0, imem_req}, 32'd1);
        check("s7_addr", imem_addr,         32'h0);
        cyc();                                    // -> WAIT, response ignored
        imem_rvalid = 1'b0;
        #1;
        check("s7_valid", {31'd0, instr_valid}, 32'd0);
        check("s7_instr", instr_out,            32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_fetch_unit

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  clock; all state is rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  32  word-aligned fetch address.
- imem_rvalid  input  1  read data valid; at most one outstanding request.
- imem_rdata  input  32  fetched instruction word.
- instr_out  output  32  buffered instruction to the decoder; opcode is instr_out[31:26].
- pc4_out  output  32  PC+4 of instr_out.
- instr_valid  output  1  instr_out/pc4_out valid.
- id_ready  input  1  decoder accepts the instruction when both instr_valid and id_ready are high.
- br_valid  input  1  resolution strobe for a control-transfer instruction.
- branch  input  1  Branch control output.
- bne  input  1  Bne control output.
- jump  input  1  Jump control output.
- zero  input  1  ALU zero flag.
- br_pc4  input  32  PC+4 of the resolving instruction.
- br_imm  input  16  branch offset in words.
- j_index  input  26  jump target index.

Function
REQ-003 redirect SHALL equal br_valid & (jump | (branch & (zero ^ bne))).
REQ-004 The jump target SHALL be {br_pc4[31:28], j_index, 2'b00}.
- jump has priority over branch.
REQ-005 The branch target SHALL be br_pc4 + (sign-extended br_imm << 2), computed modulo 2^32.
REQ-006 The FSM SHALL have states FETCH, WAIT and FULL.
- FETCH: imem_req=1, imem_addr=pc; go to WAIT next cycle.
- WAIT: imem_req=0. On imem_rvalid, latch imem_rdata into instr_out and pc+4 into pc4_out, set pc<=pc+4, then go to FULL.
- FULL: instr_valid=1. On accept, go to FETCH.
REQ-007 Fetch-to-decode latency SHALL be 2 cycles.
- imem_req in cycle N; imem_rvalid in N+1 at earliest; instr_valid in N+2.
REQ-008 instr_out and pc4_out SHALL stay stable while instr_valid=1 and id_ready=0.
REQ-009 A redirect in FETCH or FULL SHALL load pc with the target, clear instr_valid, and enter FETCH.
REQ-010 A redirect in WAIT SHALL set a drop flag and load pc with the target.
- The pending response is discarded on arrival: no instr_valid, pc not incremented.
- The FSM then enters FETCH.
REQ-011 A redirect coincident with imem_rvalid in WAIT SHALL discard that response.
REQ-012 A redirect coincident with acceptance in FULL SHALL complete the acceptance, and the next fetch SHALL use the target.
REQ-013 The pc increment SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-014 A second redirect while drop is set SHALL overwrite pc, and drop SHALL remain set.
REQ-015 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-016 While rst_n=0, the block SHALL hold the following values.
- pc=RESET_PC; state=FETCH; drop=0.
- imem_req=0; instr_valid=0.
- instr_out=0; pc4_out=0.
REQ-017 imem_req SHALL first assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.
REQ-018 A reset asserted while in WAIT SHALL abandon the outstanding request, and a late imem_rvalid SHALL be ignored per REQ-015.

Structure
REQ-019 The FSM state encoding, RESET_PC default and opcode constants (J=2, BEQ=4, BNE=5) SHALL live in a shared package, cpu_pkg.
REQ-020 Target computation (REQ-003 to REQ-005) SHALL be one combinational sub-module, next_pc_calc; all else is in pc_fetch_unit.

Verification
REQ-021 The bench SHALL cover the following directed scenarios.
- Reset release, memory returns 32'h2409_0005 one cycle after request: imem_addr=0, then instr_valid with instr_out=32'h2409_0005 and pc4_out=4.
- id_ready held low 5 cycles: instr_out stable and no new imem_req; after accept, the next imem_addr is 4.
- br_valid, branch=1, zero=1, br_pc4=32'h10, br_imm=16'hFFFC: the next imem_addr is 32'h0.
- br_valid, bne=1, branch=1, zero=1: no redirect, sequential fetch continues.
- jump=1 with br_pc4=32'hA000_0008 and j_index=26'h10 during WAIT: the response is dropped with no instr_valid, and the next imem_addr is 32'hA000_0040.
- pc=32'hFFFF_FFFC fetch completes: pc4_out=0 and the next imem_addr is 0.
